// File: rtl/dout_arb_pkg.sv
// dout_arb_pkg: shared types and sizing helpers for the round-robin output arbiter
package dout_arb_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dout_rr_pick.sv
// dout_rr_pick: combinational pick of the first valid requester at or after rr_ptr
module dout_rr_pick import dout_arb_pkg::*; #(
    parameter int NREQ = 4,
    localparam int IDW = idw(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  pick_id,
    output logic            pick_vld
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    // rotate so rr_ptr lands at bit 0, encode the lowest set bit, then rotate back
    assign dbl = {req_valid, req_valid};
    assign rot = dbl[rr_ptr +: NREQ];

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i])
                off = IDW'(i);
    end

    assign sum      = {1'b0, off} + {1'b0, rr_ptr};
    assign pick_id  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
    assign pick_vld = |req_valid;

endmodule

// File: rtl/dout_rr_arbiter.sv
// dout_rr_arbiter: burst-locked round-robin arbiter feeding one registered output stream
module dout_rr_arbiter import dout_arb_pkg::*; #(
    parameter int DWIDTH    = 16,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    localparam int IDW = idw(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [DWIDTH-1:0]      dout_data,
    output logic                   dout_valid,
    output logic                   dout_last,
    input  logic                   dout_ready,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] next_ptr;
    logic [BCW-1:0] beat_cnt;
    logic           pick_vld;
    logic           load_ok;
    logic           xfer;
    logic           rel;

    dout_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr),
        .pick_id  (pick_id),
        .pick_vld (pick_vld)
    );

    assign busy      = state == LOCK;
    assign load_ok   = !dout_valid || dout_ready;
    assign req_ready = (busy && load_ok) ? NREQ'(1) << grant_id : '0;
    assign xfer      = busy && load_ok && req_valid[grant_id];
    // a forced release at MAX_BURST leaves dout_last as the source's own flag
    assign rel       = xfer && (req_last[grant_id] || beat_cnt == BCW'(MAX_BURST - 1));
    assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            beat_cnt   <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (pick_vld) begin
                    state    <= LOCK;
                    grant_id <= pick_id;
                    beat_cnt <= '0;
                end
            end else if (xfer) begin
                beat_cnt <= rel ? '0 : beat_cnt + BCW'(1);
                if (rel) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end
            end
            if (xfer) begin
                dout_valid <= 1'b1;
                dout_data  <= req_data[grant_id*DWIDTH +: DWIDTH];
                dout_last  <= req_last[grant_id];
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dout_rr_arbiter.sv
// tb_dout_rr_arbiter: vector table, directed bursts and random traffic against a reference model
module tb_dout_rr_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int MB = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   dout_data;
    logic            dout_valid;
    logic            dout_last;
    logic            dout_ready = 1'b0;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dout_rr_arbiter #(.DWIDTH(DW), .NREQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .dout_data (dout_data),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .dout_ready(dout_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // reference model: owner = -1 when no burst is locked, output register as plain values
    int            m_owner, m_beats, m_ptr, m_gid;
    logic          m_vld, m_last;
    logic [DW-1:0] m_data;

    function automatic void m_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_gid   = 0;
        m_vld   = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
    endfunction

    function automatic logic [N-1:0] m_rdy();
        return (m_owner >= 0 && (!m_vld || dout_ready)) ? N'(1 << m_owner) : '0;
    endfunction

    function automatic void m_step();
        int  was;
        logic x;
        was = m_owner;
        x = m_owner >= 0 && req_valid[m_owner] && (!m_vld || dout_ready);
        if (x) begin
            m_vld  = 1'b1;
            m_data = req_data[m_owner*DW +: DW];
            m_last = req_last[m_owner];
            m_beats++;
            if (m_last || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (dout_ready) begin
            m_vld = 1'b0;
        end
        if (was < 0) begin
            for (int k = N - 1; k >= 0; k--)
                if (req_valid[(m_ptr + k) % N])
                    m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_gid   = m_owner;
                m_beats = 0;
            end
        end
    endfunction

    typedef struct {
        int            c;
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         outq[$];
    logic [N-1:0]  rr_seen;
    logic          prev_v, prev_r;
    logic [DW-1:0] prev_d;

    task automatic sample();
        @(negedge clk);
        cyc++;
        chk("model", 64'({req_ready, dout_valid, dout_data, dout_last, grant_id, busy, dut.rr_ptr}),
            64'({m_rdy(), m_vld, m_data, m_last, IW'(m_gid), m_owner >= 0, IW'(m_ptr)}));
        if (prev_v && !prev_r)
            chk("stall_hold", 64'({dout_valid, dout_data}), 64'({1'b1, prev_d}));
        prev_v  = dout_valid;
        prev_r  = dout_ready;
        prev_d  = dout_data;
        rr_seen = req_ready;
        if (dout_valid && dout_ready)
            outq.push_back('{cyc, dout_last, dout_data});
    endtask

    task automatic advance();
        @(posedge clk);
        m_step();
        #1;
    endtask

    // simple producers: lane i sends tot[i] beats, base[i]+n, last every blen[i] beats
    int            cnt[N], tot[N], blen[N];
    logic [DW-1:0] base[N];

    task automatic prod_step();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = cnt[i] < tot[i];
            req_last[i]  = blen[i] != 0 && (cnt[i] % blen[i]) == blen[i] - 1;
            req_data[i*DW +: DW] = base[i] + DW'(cnt[i]);
        end
        sample();
        advance();
        for (int i = 0; i < N; i++)
            if (rr_seen[i] && req_valid[i])
                cnt[i]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        dout_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        prev_v = 1'b0;
        outq.delete();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            tot[i] = 0;
            blen[i] = 0;
            base[i] = '0;
        end
    endtask

    typedef struct {
        logic          v;
        logic          l;
        logic [DW-1:0] d;
        logic          r;
        logic [N-1:0]  e_rr;
        logic          e_v;
        logic [DW-1:0] e_d;
        logic          e_l;
        logic          e_b;
        logic [IW-1:0] e_p;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int           pat[4];
        logic [DW-1:0] exp_d[12];
        logic          exp_l[12];

        // requester 0: three-beat burst 1,2,3 with last on 3, sink always ready
        tbl[0] = '{1'b1, 1'b0, 16'h0001, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 16'h0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 16'h0002, 1'b1, 4'b0001, 1'b1, 16'h0001, 1'b0, 1'b1, 2'd0};
        tbl[3] = '{1'b1, 1'b1, 16'h0003, 1'b1, 4'b0001, 1'b1, 16'h0002, 1'b0, 1'b1, 2'd0};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h0003, 1'b1, 1'b0, 2'd1};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b0, 16'h0003, 1'b1, 1'b0, 2'd1};

        do_reset();
        chk("reset_outs", 64'({req_ready, dout_valid, dout_data, dout_last, grant_id, busy}), 64'(0));
        for (int i = 0; i < 6; i++) begin
            req_valid  = {3'b000, tbl[i].v};
            req_last   = {3'b000, tbl[i].l};
            req_data   = {48'h0, tbl[i].d};
            dout_ready = tbl[i].r;
            sample();
            chk($sformatf("tbl%0d", i),
                64'({req_ready, dout_valid, dout_data, dout_last, busy, dut.rr_ptr}),
                64'({tbl[i].e_rr, tbl[i].e_v, tbl[i].e_d, tbl[i].e_l, tbl[i].e_b, tbl[i].e_p}));
            advance();
        end

        // all four requesters hold single-beat bursts: grant order 0,1,2,3,0 with one bubble
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            tot[i] = 5;
            blen[i] = 1;
            base[i] = DW'(i * 256);
        end
        for (int t = 0; t < 12; t++)
            prod_step();
        chk("rr_count", 64'(outq.size() >= 5), 64'(1));
        for (int i = 0; i < 5 && i < outq.size(); i++) begin
            chk($sformatf("rr_order%0d", i), 64'(outq[i].d), 64'((i % N) * 256 + i / N));
            if (i > 0)
                chk($sformatf("rr_gap%0d", i), 64'(outq[i].c - outq[i-1].c), 64'(2));
        end

        // requester 2 streams 10 beats without last, requester 3 has a 2-beat burst waiting
        do_reset();
        dout_ready = 1'b1;
        tot[2] = 10; blen[2] = 0; base[2] = 16'h0200;
        tot[3] = 2;  blen[3] = 2; base[3] = 16'h0300;
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = 16'h0200 + DW'(i);
            exp_l[i] = 1'b0;
        end
        exp_d[8] = 16'h0300;  exp_l[8] = 1'b0;
        exp_d[9] = 16'h0301;  exp_l[9] = 1'b1;
        exp_d[10] = 16'h0208; exp_l[10] = 1'b0;
        exp_d[11] = 16'h0209; exp_l[11] = 1'b0;
        for (int t = 0; t < 40; t++)
            prod_step();
        chk("mb_count", 64'(outq.size()), 64'(12));
        for (int i = 0; i < 12 && i < outq.size(); i++)
            chk($sformatf("mb_beat%0d", i), 64'({outq[i].l, outq[i].d}), 64'({exp_l[i], exp_d[i]}));
        chk("mb_lock_held", 64'({busy, grant_id}), 64'({1'b1, 2'd2}));

        // backpressure: sink ready pattern 1,0,0,1 while a 4-beat burst flows
        do_reset();
        tot[0] = 4; blen[0] = 4; base[0] = 16'h00A0;
        pat = '{1, 0, 0, 1};
        for (int t = 0; t < 20; t++) begin
            dout_ready = pat[t % 4] != 0;
            prod_step();
        end
        chk("bp_count", 64'(outq.size()), 64'(4));
        for (int i = 0; i < 4 && i < outq.size(); i++)
            chk($sformatf("bp_beat%0d", i), 64'({outq[i].l, outq[i].d}), 64'({i == 3, 16'h00A0 + DW'(i)}));

        // reset in the middle of requester 3's burst while an output beat is held
        do_reset();
        dout_ready = 1'b1;
        tot[1] = 1;   blen[1] = 1; base[1] = 16'h0100;
        tot[3] = 100; blen[3] = 0; base[3] = 16'h0300;
        for (int t = 0; t < 7; t++)
            prod_step();
        chk("mid_pre", 64'({dout_valid, busy, grant_id}), 64'({1'b1, 1'b1, 2'd3}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({req_ready, dout_valid, dout_data, dout_last, grant_id, busy}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        prev_v = 1'b0;
        outq.delete();
        cnt[1] = 0;
        tot[1] = 3;
        prod_step();
        chk("mid_regrant", 64'({busy, grant_id}), 64'({1'b1, 2'd1}));
        for (int t = 0; t < 4; t++)
            prod_step();

        // random traffic against the model
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            req_valid  = N'($urandom);
            req_last   = N'($urandom) & N'($urandom);
            req_data   = {$urandom, $urandom};
            dout_ready = ($urandom % 4) != 0;
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
